// File: rtl/io_input_conditioner.sv
// io_input_conditioner
// Synchronizes two push-buttons and a bank of switches, then debounces each
// button independently. A qualified press produces a one-cycle load strobe
// for the matching inport and captures the synchronized switch word.
//
// Per-button FSM states:
//   state          | meaning
//   ---------------+--------------------------------------------------------
//   ST_IDLE        | button released and stable
//   ST_PRESS_WAIT  | button seen high, counting stable high samples
//   ST_PRESSED     | press qualified, button held
//   ST_RELEASE_WAIT| button seen low while pressed, counting stable lows
module io_input_conditioner #(
  parameter int WIDTH           = 32,
  parameter int NUM_SWITCHES    = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              buttons,
  input  logic [NUM_SWITCHES-1:0] switches,
  output logic [WIDTH-1:0]        inport_data,
  output logic                    inport_0_en,
  output logic                    inport_1_en,
  output logic [1:0]              btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // A transition qualifies when the counter already holds D-1 and the
  // sample agrees once more, i.e. D consecutive agreeing samples in total.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  logic [1:0]              b_meta_q;
  logic [1:0]              b_sync_q;
  logic [NUM_SWITCHES-1:0] sw_meta_q;
  logic [NUM_SWITCHES-1:0] sw_sync_q;
  logic [1:0]              b_sync;
  logic [NUM_SWITCHES-1:0] sw_sync;

  btn_state_e              state_q [2];
  btn_state_e              state_d [2];
  logic [CNT_W-1:0]        cnt_q   [2];
  logic [CNT_W-1:0]        cnt_d   [2];
  logic [1:0]              press_evt;
  logic [1:0]              level_d;

  logic [1:0]              en_q;
  logic [1:0]              level_q;
  logic [WIDTH-1:0]        data_q;

  // Two-flop synchronizers for every raw asynchronous input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_meta_q  <= '0;
      b_sync_q  <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      b_meta_q  <= buttons;
      b_sync_q  <= b_meta_q;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign b_sync  = b_sync_q;
  assign sw_sync = sw_sync_q;

  // Debounce FSM state and counter registers, one set per button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state, counter and press-event decode for both buttons
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      press_evt[i] = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (b_sync[i]) begin
            state_d[i] = ST_PRESS_WAIT;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!b_sync[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = ST_PRESSED;
            cnt_d[i]     = '0;
            press_evt[i] = 1'b1;
          end else begin
            cnt_d[i]     = cnt_q[i] + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!b_sync[i]) begin
            state_d[i] = ST_RELEASE_WAIT;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (b_sync[i]) begin
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Debounced level follows the state being entered, so it is a flop output
  // that matches PRESSED/RELEASE_WAIT membership cycle for cycle
  always_comb begin
    level_d = '0;
    for (int i = 0; i < 2; i++) begin
      level_d[i] = (state_d[i] == ST_PRESSED) || (state_d[i] == ST_RELEASE_WAIT);
    end
  end

  // Registered strobes, level and switch capture; one load covers both buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= '0;
      level_q <= '0;
      data_q  <= '0;
    end else begin
      en_q    <= press_evt;
      level_q <= level_d;
      if (|press_evt) begin
        data_q <= WIDTH'(sw_sync);
      end
    end
  end

  assign inport_0_en = en_q[0];
  assign inport_1_en = en_q[1];
  assign btn_level   = level_q;
  assign inport_data = data_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

  localparam int WIDTH = 32;
  localparam int NSW   = 10;
  localparam int DEB   = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       buttons;
  logic [NSW-1:0]   switches;
  logic [WIDTH-1:0] inport_data;
  logic             inport_0_en;
  logic             inport_1_en;
  logic [1:0]       btn_level;

  typedef struct {
    int          cyc;
    logic        en0;
    logic        en1;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc;
  int   errors;
  int   checks;
  int   n;

  io_input_conditioner #(
    .WIDTH(WIDTH),
    .NUM_SWITCHES(NSW),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .buttons(buttons),
    .switches(switches),
    .inport_data(inport_data),
    .inport_0_en(inport_0_en),
    .inport_1_en(inport_1_en),
    .btn_level(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Monitor: every strobe must match the next expected entry, including cycle
  always @(negedge clk) begin
    if (rst && (inport_0_en || inport_1_en)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got en1/en0=%b%b data=%h expected no strobe (cyc %0d)",
                 inport_1_en, inport_0_en, inport_data, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", 32'(cyc), 32'(e.cyc));
        check("strobe_en0", 32'(inport_0_en), 32'(e.en0));
        check("strobe_en1", 32'(inport_1_en), 32'(e.en1));
        check("strobe_data", inport_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    buttons  = 2'b00;
    switches = '0;
    #1;
    check("reset_data", inport_data, 32'h0);
    check("reset_en0", 32'(inport_0_en), 32'h0);
    check("reset_en1", 32'(inport_1_en), 32'h0);
    check("reset_level", 32'(btn_level), 32'h0);
    wait_neg(3);
    rst = 1'b1;
    wait_neg(2);

    // Clean press on button 0
    switches = 10'h2A5;
    buttons  = 2'b01;
    n = cyc;
    sb.push_back('{n + 6, 1'b1, 1'b0, 32'h0000_02A5});
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 5) check("clean_level_before", 32'(btn_level), 32'h0);
      if (k == 6) check("clean_level_at", 32'(btn_level), 32'h1);
      if (k == 20) check("clean_level_held", 32'(btn_level), 32'h1);
    end
    buttons = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 5) check("release_level_wait", 32'(btn_level), 32'h1);
      if (k == 8) check("release_level_done", 32'(btn_level), 32'h0);
    end

    // Bounce on button 1: 3 high, 1 low, five times
    for (int r = 0; r < 5; r++) begin
      buttons = 2'b10;
      repeat (3) begin
        @(negedge clk);
        check("bounce_level", 32'(btn_level), 32'h0);
      end
      buttons = 2'b00;
      @(negedge clk);
      check("bounce_level", 32'(btn_level), 32'h0);
    end
    wait_neg(4);
    check("bounce_level_end", 32'(btn_level), 32'h0);

    // Simultaneous press
    switches = 10'h3FF;
    buttons  = 2'b11;
    n = cyc;
    sb.push_back('{n + 6, 1'b1, 1'b1, 32'h0000_03FF});
    wait_neg(10);
    check("simul_level", 32'(btn_level), 32'h3);
    check("simul_data", inport_data, 32'h0000_03FF);
    buttons = 2'b00;
    wait_neg(8);
    check("simul_release", 32'(btn_level), 32'h0);

    // Hold, change switches, release, re-press
    switches = 10'h155;
    buttons  = 2'b01;
    n = cyc;
    sb.push_back('{n + 6, 1'b1, 1'b0, 32'h0000_0155});
    wait_neg(8);
    switches = 10'h001;
    wait_neg(10);
    check("hold_data_kept", inport_data, 32'h0000_0155);
    buttons = 2'b00;
    wait_neg(8);
    check("hold_release", 32'(btn_level), 32'h0);
    buttons = 2'b01;
    n = cyc;
    sb.push_back('{n + 6, 1'b1, 1'b0, 32'h0000_0001});
    wait_neg(8);
    check("repress_data", inport_data, 32'h0000_0001);

    // Release glitch of 2 cycles while pressed
    buttons = 2'b00;
    repeat (2) begin
      @(negedge clk);
      check("glitch_level", 32'(btn_level), 32'h1);
    end
    buttons = 2'b01;
    repeat (8) begin
      @(negedge clk);
      check("glitch_level", 32'(btn_level), 32'h1);
    end
    buttons = 2'b00;
    wait_neg(8);
    check("glitch_release", 32'(btn_level), 32'h0);

    // Reset mid-qualification, button kept held through reset
    switches = 10'h0C3;
    buttons  = 2'b01;
    wait_neg(4);
    rst = 1'b0;
    #1;
    check("midrst_data", inport_data, 32'h0);
    check("midrst_en0", 32'(inport_0_en), 32'h0);
    check("midrst_en1", 32'(inport_1_en), 32'h0);
    check("midrst_level", 32'(btn_level), 32'h0);
    wait_neg(2);
    rst = 1'b1;
    n = cyc;
    sb.push_back('{n + 6, 1'b1, 1'b0, 32'h0000_00C3});
    wait_neg(10);
    check("postrst_data", inport_data, 32'h0000_00C3);
    check("postrst_level", 32'(btn_level), 32'h1);
    buttons = 2'b00;
    wait_neg(8);

    wait_neg(5);
    check("pending_strobes", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which is the width of the inport data word.
REQ-002 The block SHALL have parameter NUM_SWITCHES, default 10, which is the switch count; the constraint is NUM_SWITCHES <= WIDTH.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, which is the number of consecutive stable samples that qualifies a button transition; the constraint is DEBOUNCE_CYCLES >= 2.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port buttons, input, 2 bits: raw asynchronous push-buttons, active-high when pressed.
REQ-007 Port switches, input, NUM_SWITCHES bits: raw asynchronous switches.
REQ-008 Port inport_data, output, WIDTH bits: captured switch word, zero-extended, registered.
REQ-009 Port inport_0_en, output, 1 bit: one-cycle load strobe for inport 0, registered.
REQ-010 Port inport_1_en, output, 1 bit: one-cycle load strobe for inport 1, registered.
REQ-011 Port btn_level, output, 2 bits: debounced button state, registered.

Function
REQ-012 Each buttons bit and each switches bit SHALL pass through a 2-flop synchronizer; all logic after the synchronizer SHALL use only the synchronized copies (b_sync, sw_sync).
REQ-013 Each button SHALL have an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a debounce counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
REQ-014 In IDLE: if b_sync=1, the FSM SHALL go to PRESS_WAIT with cnt<=1; otherwise it stays in IDLE with cnt=0.
REQ-015 In PRESS_WAIT: if b_sync=0, the FSM SHALL go to IDLE with cnt<=0.
REQ-016 In PRESS_WAIT: if b_sync=1 and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED with cnt<=0 and raise the press event; otherwise cnt increments.
REQ-017 In PRESSED: if b_sync=0, the FSM SHALL go to RELEASE_WAIT with cnt<=1; otherwise it stays in PRESSED.
REQ-018 In RELEASE_WAIT: if b_sync=1, the FSM SHALL go to PRESSED with cnt<=0.
REQ-019 In RELEASE_WAIT: if b_sync=0 and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL go to IDLE with cnt<=0; otherwise cnt increments.
REQ-020 btn_level[i] SHALL be 1 exactly while FSM i is in PRESSED or RELEASE_WAIT.
REQ-021 A press event on button i SHALL set inport_i_en to 1 for exactly the one cycle following the qualifying edge.
REQ-022 A button held indefinitely SHALL produce exactly one strobe, and a release SHALL produce no strobe.
REQ-023 Latency SHALL be: when the pin is high on DEBOUNCE_CYCLES+2 consecutive rising edges, the strobe is high after the last of those edges.
REQ-024 On the same edge that raises any press event, inport_data SHALL load {zeros, sw_sync}; inport_data SHALL hold its value at all other times.
REQ-025 Strobe and data SHALL become valid in the same cycle.
REQ-026 Simultaneous press events on both buttons SHALL assert both strobes in the same cycle and perform a single data load.
REQ-027 Any bounce shorter than DEBOUNCE_CYCLES consecutive samples SHALL produce no strobe and no btn_level change.
REQ-028 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap around.

Reset
REQ-029 While rst=0, the synchronizers, both FSMs (forced to IDLE) and every counter SHALL clear immediately, regardless of clk.
REQ-030 While rst=0, inport_data SHALL be 0, inport_0_en and inport_1_en SHALL be 0, and btn_level SHALL be 2'b00.
REQ-031 After rst deasserts, a button already held high SHALL be treated as a new press, giving one strobe after the full qualification.
REQ-032 Reset asserted mid-qualification SHALL produce no strobe.

Verification (DEBOUNCE_CYCLES=4, NUM_SWITCHES=10, WIDTH=32)
REQ-033 Clean press: switches=10'h2A5, buttons[0] raised and held for 20 cycles -> inport_0_en high for exactly 1 cycle on the 6th edge after the first sampling edge, inport_data=32'h000002A5, btn_level[0]=1, inport_1_en stays 0.
REQ-034 Bounce: buttons[1] toggled high 3 cycles, low 1 cycle, repeated 5 times -> no strobe, btn_level[1]=0 throughout.
REQ-035 Simultaneous press: both buttons raised on the same cycle with switches=10'h3FF -> both strobes in the same cycle, inport_data=32'h000003FF, with only one load.
REQ-036 Hold then change switches: button 0 held, switches changed to 10'h001 after the strobe -> inport_data unchanged and no second strobe; after release of 6+ cycles and a re-press -> inport_data=32'h00000001.
REQ-037 Release glitch: button 0 in PRESSED drops low for 2 cycles then returns high -> btn_level[0] stays 1 and no new strobe.
REQ-038 Reset mid-operation: rst pulled low with FSM 0 in PRESS_WAIT at cnt=2 -> all outputs 0 immediately; with the button still held, release of rst gives one strobe after 6 edges.
